// File: rtl/range_tx_pkg.sv
// Shared types and default sizes for the range-finder sample-stream transmitter.
package range_tx_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefPtrW  = $clog2(DefDepth);
  localparam int unsigned DefCntW  = DefPtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StFirst,
    StMid,
    StLast,
    StDone
  } tx_state_e;

endpackage

// File: rtl/range_tx_fifo.sv
// Single-clock sample FIFO. Pointers wrap modulo Depth; count is one bit wider than the pointers
// so that full and empty are distinguishable. Pushes when full and pops when empty are ignored.
module range_tx_fifo
  import range_tx_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Depth = DefDepth,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/range_stream_tx.sv
// Range-finder stream transmitter: buffers host samples and replays them as one framed burst
// (go on the first sample, finish on the last). Optional feature macro RANGE_TX_CHECK_EN adds a
// running min/max tracker that publishes the expected max-min of the last frame on exp_range.
module range_stream_tx
  import range_tx_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Depth = DefDepth
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [Width-1:0]       wr_data,
  input  logic                   start,
  output logic [Width-1:0]       data_out,
  output logic                   go,
  output logic                   finish,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(Depth):0] count,
  output logic                   wr_err,
  output logic                   start_err,
  output logic [Width-1:0]       exp_range
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  tx_state_e        state_q, state_d;
  logic             start_ok, pop, push;
  logic             fifo_full, fifo_empty;
  logic [Width-1:0] fifo_rdata;
  logic [Width-1:0] data_q;
  logic             wr_err_q, start_err_q;

  // A frame needs at least two samples so that go and finish land on different cycles.
  assign start_ok = (state_q == StIdle) && start && (count >= CntW'(2));
  assign push     = wr_en && (state_q == StIdle) && !fifo_full && !start_ok;

  range_tx_fifo #(
    .Width (Width),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state; each sample is popped on the edge that presents it on data_out.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          pop     = 1'b1;
          state_d = StFirst;
        end
      end
      StFirst, StMid: begin
        pop     = !fifo_empty;
        state_d = (count == CntW'(1)) ? StLast : StMid;
      end
      StLast:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered sample output and one-cycle error pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q      <= '0;
      wr_err_q    <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      data_q      <= pop ? fifo_rdata : '0;
      wr_err_q    <= wr_en && !push;
      start_err_q <= (state_q == StIdle) && start && (count < CntW'(2));
    end
  end

  assign data_out  = data_q;
  assign go        = (state_q == StFirst);
  assign finish    = (state_q == StLast);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign wr_err    = wr_err_q;
  assign start_err = start_err_q;

`ifdef RANGE_TX_CHECK_EN
  logic [Width-1:0] min_q, max_q, range_q;

  // Track min/max over transmitted samples; publish max-min as the frame enters DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      min_q   <= '0;
      max_q   <= '0;
      range_q <= '0;
    end else begin
      if (pop) begin
        if (state_q == StIdle) begin
          min_q <= fifo_rdata;
          max_q <= fifo_rdata;
        end else begin
          if (fifo_rdata < min_q) min_q <= fifo_rdata;
          if (fifo_rdata > max_q) max_q <= fifo_rdata;
        end
      end
      if (state_q == StLast) range_q <= max_q - min_q;
    end
  end

  assign exp_range = range_q;
`else
  assign exp_range = '0;
`endif

endmodule
